// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - default parameters, channel state encoding and clog2 helper for the button bank
package button_pkg;

  localparam int DEF_N_BTN          = 4;
  localparam int DEF_TICK_DIV       = 400000;
  localparam int DEF_STABLE_SAMPLES = 3;
  localparam int DEF_HOLD_TICKS     = 250;
  localparam int DEF_REPEAT_TICKS   = 50;

  typedef enum logic [1:0] {
    CH_UP   = 2'd0,
    CH_DOWN = 2'd1,
    CH_LONG = 2'd2
  } chan_state_e;

  // Never returns less than 1 so it can size a vector directly.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/button_chan.sv
// rtl/button_chan.sv - one debounced button channel: sample history, level, edge pulses and hold/auto-repeat
module button_chan
  import button_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int HOLD_TICKS     = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic tick,
  input  logic eval,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic long_hold
);

  localparam int HW = clog2(HOLD_TICKS + REPEAT_TICKS + 1);
  localparam logic [HW-1:0] HOLD_AT = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] WRAP_AT = HW'(HOLD_TICKS + REPEAT_TICKS);

  chan_state_e               state;
  chan_state_e               state_nxt;
  logic [STABLE_SAMPLES-1:0] hist;
  logic [HW-1:0]             hold_cnt;
  logic [HW-1:0]             hold_nxt;
  logic [HW-1:0]             hold_inc;
  logic                      all_ones;
  logic                      all_zeros;
  logic                      rpt_hit;
  logic                      press_nxt;
  logic                      release_nxt;
  logic                      repeat_nxt;

  assign all_ones  = &hist;
  assign all_zeros = ~|hist;
  assign hold_inc  = hold_cnt + 1'b1;
  // The counter runs HOLD_AT..WRAP_AT in a loop after the first repeat, so both ends fire.
  assign rpt_hit   = (hold_inc == HOLD_AT) || (hold_inc == WRAP_AT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= CH_UP;
      hist          <= '0;
      hold_cnt      <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      if (tick) begin
        hist <= {hist[STABLE_SAMPLES-2:0], sample};
      end
      state         <= state_nxt;
      hold_cnt      <= hold_nxt;
      press         <= press_nxt;
      release_pulse <= release_nxt;
      repeat_pulse  <= repeat_nxt;
    end
  end

  // eval trails tick by one clk, so history is already updated when it is judged.
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    repeat_nxt  = 1'b0;
    if (eval) begin
      case (state)
        CH_UP: begin
          hold_nxt = '0;
          if (all_ones) begin
            state_nxt = CH_DOWN;
            press_nxt = 1'b1;
          end
        end
        CH_DOWN, CH_LONG: begin
          if (all_zeros) begin
            state_nxt   = CH_UP;
            hold_nxt    = '0;
            release_nxt = 1'b1;
          end else begin
            hold_nxt = (hold_inc == WRAP_AT) ? HOLD_AT : hold_inc;
            if (rpt_hit) begin
              repeat_nxt = 1'b1;
              state_nxt  = CH_LONG;
            end
          end
        end
        default: begin
          state_nxt = CH_UP;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    level     = (state != CH_UP);
    long_hold = (state == CH_LONG);
  end

endmodule

// File: rtl/button_bank.sv
// rtl/button_bank.sv - input synchronizers, shared sample tick and one debounce channel per button
module button_bank
  import button_pkg::*;
#(
  parameter int N_BTN          = DEF_N_BTN,
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int HOLD_TICKS     = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] in,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic [N_BTN-1:0] long_hold
);

  localparam int CW = clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;
  logic [CW-1:0]    tick_cnt;
  logic             tick;
  logic             eval;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1  <= '0;
      sync_q2  <= '0;
      tick_cnt <= '0;
      eval     <= 1'b0;
    end else begin
      sync_q1  <= in;
      sync_q2  <= sync_q1;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      eval     <= tick;
    end
  end

  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      button_chan #(
        .STABLE_SAMPLES(STABLE_SAMPLES),
        .HOLD_TICKS    (HOLD_TICKS),
        .REPEAT_TICKS  (REPEAT_TICKS)
      ) u_chan (
        .clk          (clk),
        .rst          (rst),
        .sample       (sync_q2[i]),
        .tick         (tick),
        .eval         (eval),
        .level        (level[i]),
        .press        (press[i]),
        .release_pulse(release_pulse[i]),
        .repeat_pulse (repeat_pulse[i]),
        .long_hold    (long_hold[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_button_bank.sv
// tb/tb_button_bank.sv - scoreboard bench for button_bank against a tick-level behavioural model
module tb_button_bank;

  localparam int N  = 2;
  localparam int TD = 4;
  localparam int S  = 3;
  localparam int H  = 5;
  localparam int R  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] in  = '0;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] release_pulse;
  logic [N-1:0] repeat_pulse;
  logic [N-1:0] long_hold;

  always #5 clk = ~clk;

  button_bank #(
    .N_BTN(N), .TICK_DIV(TD), .STABLE_SAMPLES(S), .HOLD_TICKS(H), .REPEAT_TICKS(R)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .level(level), .press(press),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse), .long_hold(long_hold)
  );

  typedef struct {
    int           cyc;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] rpt;
    logic [N-1:0] lvl;
    logic [N-1:0] lng;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  // Model: a tick samples the input seen two edges earlier; decisions land one edge after the tick.
  int           n;
  logic [N-1:0] p1, p2;
  bit           pend;
  int           run_val[N];
  int           run_len[N];
  int           k[N];
  logic [N-1:0] m_lvl, m_lng;

  always @(posedge clk) begin
    exp_t e;
    int   s;
    cyc++;
    if (rst) begin
      n = 0; p1 = '0; p2 = '0; pend = 0; m_lvl = '0; m_lng = '0;
      for (int c = 0; c < N; c++) begin
        run_val[c] = 0; run_len[c] = S; k[c] = 0;
      end
    end else begin
      n++;
      e.cyc = cyc; e.prs = '0; e.rel = '0; e.rpt = '0;
      if (pend) begin
        for (int c = 0; c < N; c++) begin
          if (m_lvl[c] && run_val[c] == 0 && run_len[c] >= S) begin
            m_lvl[c] = 1'b0; m_lng[c] = 1'b0; k[c] = 0; e.rel[c] = 1'b1;
          end else if (!m_lvl[c] && run_val[c] == 1 && run_len[c] >= S) begin
            m_lvl[c] = 1'b1; k[c] = 0; e.prs[c] = 1'b1;
          end else if (m_lvl[c]) begin
            k[c]++;
            if (k[c] >= H && (k[c] - H) % R == 0) begin
              e.rpt[c] = 1'b1; m_lng[c] = 1'b1;
            end
          end
        end
      end
      pend = 0;
      if (n % TD == 0) begin
        for (int c = 0; c < N; c++) begin
          s = int'(p2[c]);
          if (s == run_val[c]) begin
            if (run_len[c] < S) run_len[c]++;
          end else begin
            run_val[c] = s; run_len[c] = 1;
          end
        end
        pend = 1;
      end
      p2 = p1; p1 = in;
      e.lvl = m_lvl; e.lng = m_lng;
      if ((e.prs | e.rel | e.rpt) != '0) exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check("press",     32'(press),         32'(e.prs));
      check("release",   32'(release_pulse), 32'(e.rel));
      check("repeat",    32'(repeat_pulse),  32'(e.rpt));
      check("level",     32'(level),         32'(e.lvl));
      check("long_hold", 32'(long_hold),     32'(e.lng));
    end else if ((press | release_pulse | repeat_pulse) != '0) begin
      check("unexpected_pulse", 32'({press, release_pulse, repeat_pulse}), 32'd0);
    end
  end

  task automatic step(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic check_all_zero(input string nm);
    check(nm, 32'({level, press, release_pulse, repeat_pulse, long_hold}), 32'd0);
  endtask

  initial begin
    step(3);
    check_all_zero("reset_outputs");
    rst = 1'b0; in = 2'b01; step(24);
    in = 2'b00; step(24);
    for (int i = 0; i < 7; i++) begin
      in[0] = ~in[0]; step(6);
    end
    in = 2'b00; step(16);
    in = 2'b10; step(30 * TD);
    in = 2'b00; step(24);
    in = 2'b11; step(40);
    in = 2'b00; step(24);
    in = 2'b11; step(25);
    rst = 1'b1; step(1);
    check_all_zero("mid_hold_reset");
    rst = 1'b0; step(24);
    in = 2'b00; step(24);
    for (int len = 36; len < 52; len++) begin
      in = 2'b01; step(len);
      in = 2'b00; step(24);
    end
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1; step(1);
        check_all_zero("random_reset");
        rst = 1'b0;
      end
      in = N'($urandom_range(0, 3));
      step(int'($urandom_range(1, 40)));
    end
    in = 2'b00; step(30);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
